// File: rtl/calc_ctrl_if.sv
// Keypad-controller bus: key input, arithmetic handshake and register-block strobes.
`timescale 1ns/1ps
interface calc_ctrl_if;
   localparam int unsigned KEY_W = 5;
   localparam int unsigned HEX_W = 4;
   localparam int unsigned OP_W  = 2;

   logic             keyvalid;
   logic [KEY_W-1:0] keycode;
   logic             arith_done;
   logic             newhex;
   logic [HEX_W-1:0] hexcode;
   logic             newop;
   logic             eq;
   logic             clr;
   logic [OP_W-1:0]  opsel;
   logic             arith_start;
   logic             busy;
   logic             overrun;
   logic             err;

   modport master (
      input  keyvalid, keycode, arith_done,
      output newhex, hexcode, newop, eq, clr, opsel, arith_start, busy, overrun, err
   );

   modport slave (
      output keyvalid, keycode, arith_done,
      input  newhex, hexcode, newop, eq, clr, opsel, arith_start, busy, overrun, err
   );
endinterface

// File: rtl/calc_controller.sv
// Keypad calculator controller: routes digits/operators to the register block and sequences the ALU.
// Optional arithmetic watchdog enabled by defining CALC_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module calc_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic         clock,
   input  logic         reset,
   calc_ctrl_if.master  bus
);
   localparam int unsigned CNT_W      = 3;
   localparam int unsigned MAX_DIGITS = 4;
   localparam logic [4:0]  KEY_ADD    = 5'h10;
   localparam logic [4:0]  KEY_SUB    = 5'h11;
   localparam logic [4:0]  KEY_MUL    = 5'h12;
   localparam logic [4:0]  KEY_EQU    = 5'h13;
   localparam logic [4:0]  KEY_CLR    = 5'h14;
   localparam logic [1:0]  OP_ADD     = 2'd0;

   typedef enum logic [1:0] {IDLE, START, WAIT, COMMIT} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             op_vld, op_vld_nx;
   logic             newhex_nx, newop_nx, clr_nx, overrun_nx, err_nx;
   logic [3:0]       hexcode_nx;
   logic [1:0]       opsel_nx;
   logic             key_used, key_clr, tmo;

`ifdef CALC_CTRL_TIMEOUT_EN
   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMR_W-1:0] tmr, tmr_nx;

   // Watchdog counts consecutive WAIT cycles; cleared whenever we are elsewhere.
   always_comb begin
      tmr_nx = '0;
      if (state == WAIT) tmr_nx = tmr + 1'b1;
      tmo = (state == WAIT) && (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clock) begin
      if (reset) tmr <= '0;
      else       tmr <= tmr_nx;
   end
`else
   assign tmo = 1'b0;
`endif

   assign key_used = bus.keyvalid && (bus.keycode <= KEY_CLR);
   assign key_clr  = bus.keyvalid && (bus.keycode == KEY_CLR);

   // Next-state and next-output decode
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      op_vld_nx  = op_vld;
      opsel_nx   = bus.opsel;
      overrun_nx = bus.overrun;
      err_nx     = bus.err;
      newhex_nx  = 1'b0;
      hexcode_nx = 4'd0;
      newop_nx   = 1'b0;
      clr_nx     = 1'b0;

      if (key_clr) begin
         state_nx   = IDLE;
         cnt_nx     = '0;
         op_vld_nx  = 1'b0;
         opsel_nx   = OP_ADD;
         overrun_nx = 1'b0;
         err_nx     = 1'b0;
         clr_nx     = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (key_used) begin
                  if (!bus.keycode[4]) begin
                     if (cnt < CNT_W'(MAX_DIGITS)) begin
                        newhex_nx  = 1'b1;
                        hexcode_nx = bus.keycode[3:0];
                        cnt_nx     = cnt + 1'b1;
                     end
                  end else if (bus.keycode == KEY_ADD || bus.keycode == KEY_SUB ||
                               bus.keycode == KEY_MUL) begin
                     newop_nx  = 1'b1;
                     opsel_nx  = bus.keycode[1:0];
                     op_vld_nx = 1'b1;
                     cnt_nx    = '0;
                  end else if (bus.keycode == KEY_EQU && op_vld) begin
                     state_nx = START;
                  end
               end
            end
            START: begin
               if (key_used) overrun_nx = 1'b1;
               state_nx = WAIT;
            end
            WAIT: begin
               if (key_used) overrun_nx = 1'b1;
               if (bus.arith_done) begin
                  state_nx = COMMIT;
               end else if (tmo) begin
                  state_nx = IDLE;
                  err_nx   = 1'b1;
               end
            end
            COMMIT: begin
               if (key_used) overrun_nx = 1'b1;
               cnt_nx   = '0;
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // State and registered outputs; strobes track the state being entered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         op_vld          <= 1'b0;
         bus.newhex      <= 1'b0;
         bus.hexcode     <= 4'd0;
         bus.newop       <= 1'b0;
         bus.eq          <= 1'b0;
         bus.clr         <= 1'b0;
         bus.opsel       <= OP_ADD;
         bus.arith_start <= 1'b0;
         bus.busy        <= 1'b0;
         bus.overrun     <= 1'b0;
         bus.err         <= 1'b0;
      end else begin
         state           <= state_nx;
         cnt             <= cnt_nx;
         op_vld          <= op_vld_nx;
         bus.newhex      <= newhex_nx;
         bus.hexcode     <= hexcode_nx;
         bus.newop       <= newop_nx;
         bus.eq          <= (state_nx == COMMIT);
         bus.clr         <= clr_nx;
         bus.opsel       <= opsel_nx;
         bus.arith_start <= (state_nx == START);
         bus.busy        <= (state_nx != IDLE);
         bus.overrun     <= overrun_nx;
         bus.err         <= err_nx;
      end
   end
endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller; timeout scenario follows CALC_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_calc_controller;
   localparam logic [4:0] K_ADD = 5'h10;
   localparam logic [4:0] K_SUB = 5'h11;
   localparam logic [4:0] K_MUL = 5'h12;
   localparam logic [4:0] K_EQU = 5'h13;
   localparam logic [4:0] K_CLR = 5'h14;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   eq_seen = 0;

   calc_ctrl_if bus();

   calc_controller #(.TIMEOUT_CYCLES(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (bus.eq === 1'b1) eq_seen++;

   function automatic logic [13:0] outs();
      return {bus.newhex, bus.hexcode, bus.newop, bus.eq, bus.clr, bus.opsel,
              bus.arith_start, bus.busy, bus.overrun, bus.err};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [4:0] code);
      bus.keyvalid = 1'b1;
      bus.keycode  = code;
      step();
      bus.keyvalid = 1'b0;
      bus.keycode  = 5'h00;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_cmp++; if (outs() !== 14'h0) begin n_err++; $display("FAIL reset_outs got %h exp 0000", outs()); end
   endtask

   task automatic test_digits();
      for (int i = 1; i <= 4; i++) begin
         press(5'(i));
         n_cmp++; if (bus.newhex !== 1'b1) begin n_err++; $display("FAIL digit%0d_newhex got %b exp 1", i, bus.newhex); end
         n_cmp++; if (bus.hexcode !== 4'(i)) begin n_err++; $display("FAIL digit%0d_hexcode got %h exp %h", i, bus.hexcode, 4'(i)); end
      end
      press(5'h05);
      n_cmp++; if (bus.newhex !== 1'b0) begin n_err++; $display("FAIL fifth_digit_newhex got %b exp 0", bus.newhex); end
      n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL fifth_digit_overrun got %b exp 0", bus.overrun); end
   endtask

   task automatic test_operator_equals();
      int e0;
      press(K_CLR);
      n_cmp++; if (bus.clr !== 1'b1) begin n_err++; $display("FAIL op_pre_clr got %b exp 1", bus.clr); end
      press(5'h07);
      n_cmp++; if (bus.hexcode !== 4'h7 || bus.newhex !== 1'b1) begin n_err++; $display("FAIL op_digit7 got %b/%h exp 1/7", bus.newhex, bus.hexcode); end
      press(K_MUL);
      n_cmp++; if (bus.newop !== 1'b1) begin n_err++; $display("FAIL mul_newop got %b exp 1", bus.newop); end
      n_cmp++; if (bus.opsel !== 2'd2) begin n_err++; $display("FAIL mul_opsel got %0d exp 2", bus.opsel); end
      step();
      n_cmp++; if (bus.newop !== 1'b0) begin n_err++; $display("FAIL mul_newop_once got %b exp 0", bus.newop); end
      press(5'h03);
      n_cmp++; if (bus.newhex !== 1'b1 || bus.hexcode !== 4'h3) begin n_err++; $display("FAIL op_digit3 got %b/%h exp 1/3", bus.newhex, bus.hexcode); end
      e0 = eq_seen;
      press(K_EQU);
      n_cmp++; if (bus.arith_start !== 1'b1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL start_pulse got %b/%b exp 1/1", bus.arith_start, bus.busy); end
      n_cmp++; if (bus.opsel !== 2'd2) begin n_err++; $display("FAIL start_opsel got %0d exp 2", bus.opsel); end
      step();
      n_cmp++; if (bus.arith_start !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL wait_state got %b/%b exp 0/1", bus.arith_start, bus.busy); end
      step();
      step();
      bus.arith_done = 1'b1;
      step();
      bus.arith_done = 1'b0;
      n_cmp++; if (bus.eq !== 1'b1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL commit_eq got %b/%b exp 1/1", bus.eq, bus.busy); end
      step();
      n_cmp++; if (bus.eq !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL after_commit got %b/%b exp 0/0", bus.eq, bus.busy); end
      n_cmp++; if (eq_seen - e0 !== 1) begin n_err++; $display("FAIL eq_count got %0d exp 1", eq_seen - e0); end
   endtask

   task automatic test_overrun_in_wait();
      press(K_EQU);
      step();
      press(5'h05);
      n_cmp++; if (bus.newhex !== 1'b0) begin n_err++; $display("FAIL wait_key_newhex got %b exp 0", bus.newhex); end
      n_cmp++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL wait_key_overrun got %b exp 1", bus.overrun); end
      press(K_CLR);
      n_cmp++; if (bus.clr !== 1'b1 || bus.overrun !== 1'b0) begin n_err++; $display("FAIL clear_overrun got %b/%b exp 1/0", bus.clr, bus.overrun); end
      n_cmp++; if (bus.busy !== 1'b0 || bus.opsel !== 2'd0) begin n_err++; $display("FAIL clear_state got %b/%0d exp 0/0", bus.busy, bus.opsel); end
   endtask

   task automatic test_clear_in_wait();
      int e0;
      e0 = eq_seen;
      press(K_ADD);
      n_cmp++; if (bus.newop !== 1'b1 || bus.opsel !== 2'd0) begin n_err++; $display("FAIL add_newop got %b/%0d exp 1/0", bus.newop, bus.opsel); end
      press(K_EQU);
      step();
      press(K_CLR);
      n_cmp++; if (bus.clr !== 1'b1 || bus.eq !== 1'b0) begin n_err++; $display("FAIL wait_clear got %b/%b exp 1/0", bus.clr, bus.eq); end
      bus.arith_done = 1'b1;
      step();
      bus.arith_done = 1'b0;
      step();
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL late_done_busy got %b exp 0", bus.busy); end
      n_cmp++; if (eq_seen !== e0) begin n_err++; $display("FAIL late_done_eq got %0d exp %0d", eq_seen, e0); end
   endtask

   task automatic test_unused_and_bare_equals();
      press(K_EQU);
      n_cmp++; if (bus.arith_start !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL bare_equals got %b/%b exp 0/0", bus.arith_start, bus.busy); end
      press(5'h15);
      n_cmp++; if (outs() !== 14'h0) begin n_err++; $display("FAIL unused15 got %h exp 0000", outs()); end
      press(5'h1F);
      n_cmp++; if (outs() !== 14'h0) begin n_err++; $display("FAIL unused1f got %h exp 0000", outs()); end
   endtask

   task automatic test_timeout();
      int e0;
      e0 = eq_seen;
      press(K_SUB);
      n_cmp++; if (bus.opsel !== 2'd1) begin n_err++; $display("FAIL sub_opsel got %0d exp 1", bus.opsel); end
      press(K_EQU);
      repeat (16) step();
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL wait16_busy got %b exp 1", bus.busy); end
`ifdef CALC_CTRL_TIMEOUT_EN
      step();
      n_cmp++; if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin n_err++; $display("FAIL timeout got %b/%b exp 0/1", bus.busy, bus.err); end
      n_cmp++; if (eq_seen !== e0) begin n_err++; $display("FAIL timeout_eq got %0d exp %0d", eq_seen, e0); end
      press(K_CLR);
      n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL clear_err got %b exp 0", bus.err); end
`else
      repeat (24) step();
      n_cmp++; if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin n_err++; $display("FAIL no_timeout got %b/%b exp 1/0", bus.busy, bus.err); end
      n_cmp++; if (eq_seen !== e0) begin n_err++; $display("FAIL no_timeout_eq got %0d exp %0d", eq_seen, e0); end
      press(K_CLR);
      n_cmp++; if (bus.clr !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL wait_forever_clear got %b/%b exp 1/0", bus.clr, bus.busy); end
`endif
   endtask

   task automatic test_reset_with_equals();
      press(K_ADD);
      reset        = 1'b1;
      bus.keyvalid = 1'b1;
      bus.keycode  = K_EQU;
      step();
      reset        = 1'b0;
      bus.keyvalid = 1'b0;
      bus.keycode  = 5'h00;
      n_cmp++; if (outs() !== 14'h0) begin n_err++; $display("FAIL reset_equals_outs got %h exp 0000", outs()); end
      step();
      n_cmp++; if (bus.arith_start !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_equals_after got %b/%b exp 0/0", bus.arith_start, bus.busy); end
   endtask

   initial begin
      bus.keyvalid   = 1'b0;
      bus.keycode    = 5'h00;
      bus.arith_done = 1'b0;
      test_reset();
      test_digits();
      test_operator_equals();
      test_overrun_in_wait();
      test_clear_in_wait();
      test_unused_and_bare_equals();
      test_timeout();
      test_reset_with_equals();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the arithmetic-done watchdog limit in clock cycles.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port keyvalid  input  1  one-cycle pulse marking a valid keypress.
REQ-005 SHALL have port keycode  input  5  key identity: 0x00-0x0F hex digit, 0x10 ADD, 0x11 SUB, 0x12 MUL, 0x13 EQUALS, 0x14 CLEAR, 0x15-0x1F unused.
REQ-006 SHALL have port arith_done  input  1  arithmetic unit result-valid pulse.
REQ-007 SHALL have port newhex  output  1  one-cycle digit strobe to the register block.
REQ-008 SHALL have port hexcode  output  4  digit value, valid while newhex=1.
REQ-009 SHALL have port newop  output  1  one-cycle operator strobe to the register block.
REQ-010 SHALL have port eq  output  1  one-cycle strobe; the register block latches answer.
REQ-011 SHALL have port clr  output  1  one-cycle clear strobe.
REQ-012 SHALL have port opsel  output  2  pending operator: 0 ADD, 1 SUB, 2 MUL.
REQ-013 SHALL have port arith_start  output  1  one-cycle arithmetic start pulse.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port overrun  output  1  sticky flag: a key was dropped.
REQ-016 SHALL have port err  output  1  sticky flag: arithmetic timeout.

Function
REQ-017 SHALL implement the FSM states IDLE, START, WAIT and COMMIT.
REQ-018 SHALL make all outputs registered, with one cycle of latency from the keyvalid sample to the corresponding strobe.
REQ-019 SHALL, in IDLE, on a digit key with digit count <4, pulse newhex with hexcode=keycode[3:0] and increment the digit count.
REQ-020 SHALL, in IDLE, ignore a digit key when the digit count is 4, without setting overrun.
REQ-021 SHALL, in IDLE, on an ADD, SUB or MUL key, pulse newop, load opsel with the new operator and zero the digit count.
REQ-022 SHALL, in IDLE, on an EQUALS key, enter START; START drives arith_start=1 for exactly one cycle with the current opsel, then goes to WAIT.
REQ-023 SHALL sample arith_done only in WAIT; arith_done in any other state is ignored.
REQ-024 SHALL, on arith_done in WAIT, go to COMMIT; COMMIT pulses eq for one cycle, zeroes the digit count, and returns to IDLE.
REQ-025 SHALL ignore an EQUALS key when no operator has been entered since reset or clear, and use opsel=ADD for it.
REQ-026 SHALL, in any state, on a CLEAR key, pulse clr, return to IDLE, zero the digit count, reset opsel to ADD, and clear overrun and err, without producing eq.
REQ-027 SHALL ignore any non-CLEAR key arriving in START, WAIT or COMMIT and set overrun.
REQ-028 SHALL ignore unused keycodes 0x15-0x1F in all states.
REQ-029 SHALL never assert more than one of newhex, newop, eq or clr in the same cycle.

Reset
REQ-030 SHALL, on reset, set the state to IDLE, opsel=0, the digit count to 0, and newhex, hexcode, newop, eq, clr, arith_start, busy, overrun and err all to 0.
REQ-031 SHALL let reset take priority over keyvalid and arith_done in the same cycle, and abort any pending operation without producing an eq pulse.

Configuration
REQ-032 SHALL, with CALC_CTRL_TIMEOUT_EN defined, count cycles in WAIT; on reaching TIMEOUT_CYCLES without arith_done, it returns to IDLE, sets err, and produces no eq pulse.
REQ-033 SHALL, without CALC_CTRL_TIMEOUT_EN, wait in WAIT indefinitely, tie err to 0, and leave TIMEOUT_CYCLES unused.

Verification
REQ-034 SHALL cover: keys 1,2,3,4,5 -> newhex pulses with hexcode 1,2,3,4 only; the fifth key produces no strobe and overrun=0.
REQ-035 SHALL cover: keys 7, MUL, 3, EQUALS, then arith_done 3 cycles after arith_start -> newop once, opsel=2, arith_start one cycle after EQUALS, eq exactly one cycle after arith_done, busy high from START through COMMIT.
REQ-036 SHALL cover: key 5 during WAIT -> no newhex and overrun=1; a following CLEAR -> clr pulse and overrun=0.
REQ-037 SHALL cover: CLEAR during WAIT, then arith_done -> state IDLE, no eq pulse at any point.
REQ-038 SHALL cover, with CALC_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: EQUALS with no arith_done -> return to IDLE after 16 WAIT cycles, err=1, no eq pulse.
REQ-039 SHALL cover: reset asserted in the same cycle as an EQUALS key -> no arith_start, and all outputs 0 on the next cycle.
